// File: rtl/ps2_rx_pkg.sv
// Shared types and helpers for the multi-channel PS/2 device-to-host receiver.
package ps2_rx_pkg;

  typedef enum logic [1:0] {ST_IDLE, ST_DATA, ST_PARITY, ST_STOP} ps2_state_t;

  localparam int unsigned PS2_DATA_BITS = 8;

  // PS/2 frames carry odd parity over the eight data bits plus the parity bit.
  function automatic logic odd_parity_ok(input logic [PS2_DATA_BITS-1:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_rx_chan.sv
// One PS/2 receive channel: synchroniser, glitch filter, frame decoder with
// inactivity timeout, FWFT byte FIFO and sticky error flags.
module ps2_rx_chan
  import ps2_rx_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter int unsigned FILTER_LEN  = 8,
  parameter int unsigned TIMEOUT_CYC = 100000
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_ps2_clk,
  input  logic                     i_ps2_data,
  input  logic                     i_rd_en,
  input  logic                     i_err_clr,
  output logic [PS2_DATA_BITS-1:0] o_rd_data,
  output logic                     o_rd_valid,
  output logic                     o_parity_err,
  output logic                     o_frame_err,
  output logic                     o_overflow
);

  localparam int unsigned AW  = $clog2(FIFO_DEPTH);
  localparam int unsigned CW  = AW + 1;
  localparam int unsigned FCW = $clog2(FILTER_LEN + 1);
  localparam int unsigned TCW = $clog2(TIMEOUT_CYC + 1);

  logic [1:0]               r_clk_s, r_dat_s;
  logic                     r_clk_f, r_dat_f, r_clk_fd;
  logic [FCW-1:0]           r_clk_cnt, r_dat_cnt;
  ps2_state_t               r_state;
  logic [2:0]               r_bit_cnt;
  logic [PS2_DATA_BITS-1:0] r_shift;
  logic                     r_par;
  logic [TCW-1:0]           r_to_cnt;
  logic [PS2_DATA_BITS-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]            r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]            r_count;
  logic                     r_parity_err, r_frame_err, r_overflow;

  logic w_fall, w_par_ok, w_stop_evt, w_push, w_timeout;
  logic w_par_set, w_frm_set, w_ovf_set, w_pop, w_full, w_wr;

  // Level only moves after FILTER_LEN consecutive disagreeing synced samples.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_clk_s   <= 2'b11;
      r_dat_s   <= 2'b11;
      r_clk_f   <= 1'b1;
      r_dat_f   <= 1'b1;
      r_clk_fd  <= 1'b1;
      r_clk_cnt <= '0;
      r_dat_cnt <= '0;
    end else begin
      r_clk_s  <= {r_clk_s[0], i_ps2_clk};
      r_dat_s  <= {r_dat_s[0], i_ps2_data};
      r_clk_fd <= r_clk_f;
      if (r_clk_s[1] != r_clk_f) begin
        if (r_clk_cnt == FCW'(FILTER_LEN - 1)) begin
          r_clk_f   <= r_clk_s[1];
          r_clk_cnt <= '0;
        end else begin
          r_clk_cnt <= r_clk_cnt + FCW'(1);
        end
      end else begin
        r_clk_cnt <= '0;
      end
      if (r_dat_s[1] != r_dat_f) begin
        if (r_dat_cnt == FCW'(FILTER_LEN - 1)) begin
          r_dat_f   <= r_dat_s[1];
          r_dat_cnt <= '0;
        end else begin
          r_dat_cnt <= r_dat_cnt + FCW'(1);
        end
      end else begin
        r_dat_cnt <= '0;
      end
    end
  end

  assign w_fall     = r_clk_fd & ~r_clk_f;
  assign w_par_ok   = odd_parity_ok(r_shift, r_par);
  assign w_stop_evt = w_fall && (r_state == ST_STOP);
  assign w_push     = w_stop_evt && r_dat_f && w_par_ok;
  assign w_timeout  = !w_fall && (r_state != ST_IDLE) && (r_to_cnt == TCW'(TIMEOUT_CYC - 1));
  assign w_par_set  = w_stop_evt && !w_par_ok;
  assign w_frm_set  = (w_stop_evt && !r_dat_f) || w_timeout;
  assign w_pop      = i_rd_en && (r_count != '0);
  assign w_full     = (r_count == CW'(FIFO_DEPTH));
  // A pop frees the slot the push lands in, so full+push+pop is not an overflow.
  assign w_wr       = w_push && (!w_full || w_pop);
  assign w_ovf_set  = w_push && w_full && !w_pop;

  // Frame decoder; the timeout returns to IDLE and drops the partial byte.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state   <= ST_IDLE;
      r_bit_cnt <= '0;
      r_shift   <= '0;
      r_par     <= 1'b0;
      r_to_cnt  <= '0;
    end else begin
      if (w_fall || (r_state == ST_IDLE)) r_to_cnt <= '0;
      else if (!w_timeout)                r_to_cnt <= r_to_cnt + TCW'(1);

      if (w_timeout) begin
        r_state <= ST_IDLE;
      end else if (w_fall) begin
        case (r_state)
          ST_IDLE: begin
            if (!r_dat_f) begin
              r_state   <= ST_DATA;
              r_bit_cnt <= '0;
            end
          end
          ST_DATA: begin
            r_shift <= {r_dat_f, r_shift[PS2_DATA_BITS-1:1]};
            if (r_bit_cnt == 3'd7) r_state <= ST_PARITY;
            else                   r_bit_cnt <= r_bit_cnt + 3'd1;
          end
          ST_PARITY: begin
            r_par   <= r_dat_f;
            r_state <= ST_STOP;
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= r_shift;
  end

  // Pointers wrap naturally since FIFO_DEPTH is a power of two; clear beats set on flags.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_parity_err <= 1'b0;
      r_frame_err  <= 1'b0;
      r_overflow   <= 1'b0;
    end else begin
      if (w_wr)  r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      if (i_err_clr)      r_parity_err <= 1'b0;
      else if (w_par_set) r_parity_err <= 1'b1;
      if (i_err_clr)      r_frame_err  <= 1'b0;
      else if (w_frm_set) r_frame_err  <= 1'b1;
      if (i_err_clr)      r_overflow   <= 1'b0;
      else if (w_ovf_set) r_overflow   <= 1'b1;
    end
  end

  assign o_rd_valid   = (r_count != '0);
  assign o_rd_data    = o_rd_valid ? r_mem[r_rd_ptr] : '0;
  assign o_parity_err = r_parity_err;
  assign o_frame_err  = r_frame_err;
  assign o_overflow   = r_overflow;

endmodule

// File: rtl/ps2_multi_rx.sv
// Multi-channel PS/2 receiver: independent per-port receive channels side by side.
module ps2_multi_rx
  import ps2_rx_pkg::*;
#(
  parameter int unsigned CHANNELS    = 2,
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter int unsigned FILTER_LEN  = 8,
  parameter int unsigned TIMEOUT_CYC = 100000
) (
  input  logic                                clk_sys,
  input  logic                                RESET,
  input  logic [CHANNELS-1:0]                 ps2_clk,
  input  logic [CHANNELS-1:0]                 ps2_data,
  input  logic [CHANNELS-1:0]                 rd_en,
  output logic [PS2_DATA_BITS*CHANNELS-1:0]   rd_data,
  output logic [CHANNELS-1:0]                 rd_valid,
  output logic [CHANNELS-1:0]                 parity_err,
  output logic [CHANNELS-1:0]                 frame_err,
  output logic [CHANNELS-1:0]                 overflow,
  input  logic [CHANNELS-1:0]                 err_clr
);

  for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
    ps2_rx_chan #(
      .FIFO_DEPTH  (FIFO_DEPTH),
      .FILTER_LEN  (FILTER_LEN),
      .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_chan (
      .i_clk        (clk_sys),
      .i_rst        (RESET),
      .i_ps2_clk    (ps2_clk[g]),
      .i_ps2_data   (ps2_data[g]),
      .i_rd_en      (rd_en[g]),
      .i_err_clr    (err_clr[g]),
      .o_rd_data    (rd_data[g*PS2_DATA_BITS +: PS2_DATA_BITS]),
      .o_rd_valid   (rd_valid[g]),
      .o_parity_err (parity_err[g]),
      .o_frame_err  (frame_err[g]),
      .o_overflow   (overflow[g])
    );
  end

endmodule
